// File: rtl/cga_sequencer_if.sv
// CGA sequencer bus: mode/enable inputs, CPU VRAM handshake and the per-character
// strobes that the sequencer hands to the CRTC and pixel stage.
interface cga_sequencer_if;
    logic       hres_mode;
    logic       video_enabled;
    logic       cpu_req;
    logic [4:0] clk_seq;
    logic       crtc_clk;
    logic       vram_rd;
    logic       vram_a0;
    logic       vram_read_char;
    logic       vram_read_att;
    logic       charrom_read;
    logic       disp_pipeline;
    logic       cpu_grant;
    logic       cpu_ack;

    modport master (
        output hres_mode, video_enabled, cpu_req,
        input  clk_seq, crtc_clk, vram_rd, vram_a0, vram_read_char, vram_read_att,
               charrom_read, disp_pipeline, cpu_grant, cpu_ack
    );

    modport slave (
        input  hres_mode, video_enabled, cpu_req,
        output clk_seq, crtc_clk, vram_rd, vram_a0, vram_read_char, vram_read_att,
               charrom_read, disp_pipeline, cpu_grant, cpu_ack
    );
endinterface

// File: rtl/cga_sequencer.sv
// CGA character-cycle sequencer: 32-clk sequence, display fetch strobes and CPU VRAM
// arbiter. Define CGA_SNOW_EN to let hi-res CPU grants ignore the window (snow).
module cga_sequencer (
    input  logic           clk,
    input  logic           reset_n,
    cga_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [4:0] seq_q, seq_d;
    logic       hres_q, hres_d;
    logic       started_q;
    logic [1:0] state_q, state_d;
    logic [4:0] phase_d;
    logic       window_d;
    logic       fast_grant;

    logic crtc_q, rd_q, a0_q, rchar_q, ratt_q, crom_q, dpipe_q, grant_q, ack_q;

    // Every output is a register decoded from the next-cycle sequence/mode/state, so
    // the values here describe the cycle that begins at the coming edge.
    always_comb begin
        // The first edge after reset holds the count at 0 and acts as a sequence start.
        seq_d    = started_q ? seq_q + 5'd1 : 5'd0;
        hres_d   = (!started_q || seq_q == 5'd31) ? bus.hres_mode : hres_q;
        phase_d  = hres_d ? {1'b0, seq_d[3:0]} : seq_d;
        window_d = hres_d ? (seq_d[3:0] == 4'd8) : (seq_d == 5'd8 || seq_d == 5'd24);
    end

`ifdef CGA_SNOW_EN
    assign fast_grant = hres_d;
`else
    assign fast_grant = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.cpu_req) state_d = S_WAIT;
            S_WAIT: begin
                if (!bus.cpu_req)                state_d = S_IDLE;
                else if (window_d || fast_grant) state_d = S_GRANT;
            end
            S_GRANT: state_d = S_ACK;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q     <= 5'd0;
            hres_q    <= 1'b0;
            started_q <= 1'b0;
            state_q   <= S_IDLE;
            crtc_q    <= 1'b0;
            rd_q      <= 1'b0;
            a0_q      <= 1'b0;
            rchar_q   <= 1'b0;
            ratt_q    <= 1'b0;
            crom_q    <= 1'b0;
            dpipe_q   <= 1'b0;
            grant_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            seq_q     <= seq_d;
            hres_q    <= hres_d;
            started_q <= 1'b1;
            state_q   <= state_d;
            crtc_q    <= (seq_d == 5'd0) || (hres_d && seq_d == 5'd16);
            rd_q      <= bus.video_enabled && (phase_d == 5'd2 || phase_d == 5'd4);
            a0_q      <= bus.video_enabled && (phase_d == 5'd4);
            rchar_q   <= bus.video_enabled && (phase_d == 5'd3);
            ratt_q    <= bus.video_enabled && (phase_d == 5'd5);
            crom_q    <= bus.video_enabled && (phase_d == 5'd6);
            dpipe_q   <= (phase_d == 5'd7);
            grant_q   <= (state_d == S_GRANT);
            // Ack lands the cycle after ACK; a request still held then starts anew.
            ack_q     <= (state_q == S_ACK);
        end
    end

    assign bus.clk_seq        = seq_q;
    assign bus.crtc_clk       = crtc_q;
    assign bus.vram_rd        = rd_q;
    assign bus.vram_a0        = a0_q;
    assign bus.vram_read_char = rchar_q;
    assign bus.vram_read_att  = ratt_q;
    assign bus.charrom_read   = crom_q;
    assign bus.disp_pipeline  = dpipe_q;
    assign bus.cpu_grant      = grant_q;
    assign bus.cpu_ack        = ack_q;
endmodule

// File: doc/cga_sequencer.md
CGA_SEQUENCER -- requirements
Module: cga_sequencer

Interface
REQ-001 clk  in  1  pixel clock; all state changes on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 hres_mode  in  1  1 = 80-column / hi-res character timing (16 clk per char), 0 = low-res (32 clk per char).
REQ-004 video_enabled  in  1  0 suppresses display fetch strobes; sequence counter still runs.
REQ-005 cpu_req  in  1  CPU VRAM access request, level, held until cpu_ack.
REQ-006 clk_seq  out  5  free-running sequence counter to pixel stage.
REQ-007 crtc_clk  out  1  one-cycle character-clock enable to CRTC.
REQ-008 vram_rd  out  1  display VRAM read cycle.
REQ-009 vram_a0  out  1  byte select for display read: 0 = char, 1 = attribute.
REQ-010 vram_read_char, vram_read_att, charrom_read, disp_pipeline  out  1 each  one-cycle latch strobes to pixel stage.
REQ-011 cpu_grant  out  1  one-cycle pulse: VRAM bus owned by CPU this cycle.
REQ-012 cpu_ack  out  1  one-cycle pulse: CPU access complete.

Function
REQ-013 clk_seq SHALL increment by 1 every clk, wrapping 31 -> 0.
REQ-014 Effective mode hres_q SHALL be captured from hres_mode only in the cycle clk_seq==31; a change mid-sequence has no effect until the wrap.
REQ-015 Phase p SHALL be clk_seq[3:0] when hres_q=1, clk_seq[4:0] when hres_q=0.
REQ-016 crtc_clk SHALL be 1 in the cycle clk_seq==0, and also when clk_seq==16 if hres_q=1; otherwise 0.
REQ-017 With video_enabled=1: vram_rd=1, vram_a0=0 at p==2; vram_rd=1, vram_a0=1 at p==4; vram_read_char=1 at p==3; vram_read_att=1 at p==5; charrom_read=1 at p==6; disp_pipeline=1 at p==7; all other cycles 0.
REQ-018 With video_enabled=0, vram_rd, vram_read_char, vram_read_att, charrom_read SHALL stay 0; disp_pipeline and crtc_clk unaffected.
REQ-019 CPU window: p==8 (hres_q=1) or clk_seq==8 or clk_seq==24 (hres_q=0).
REQ-020 Arbiter FSM states IDLE, WAIT, GRANT, ACK: IDLE->WAIT on cpu_req=1; WAIT->GRANT at next window cycle (cpu_grant=1 in that cycle); GRANT->ACK next cycle; ACK drives cpu_ack=1 one cycle then ->IDLE.
REQ-021 Request arriving in the window cycle itself SHALL wait for the following window (one cycle of registered request before grant).
REQ-022 cpu_req still 1 in the cycle after ACK SHALL be treated as a new request.
REQ-023 cpu_grant and vram_rd SHALL never both be 1 (without CGA_SNOW_EN).
REQ-024 A cpu_req deasserted in WAIT SHALL return FSM to IDLE with no grant.
REQ-025 All outputs SHALL be registered (decoded from next-state), no combinational path from cpu_req to outputs.

Reset
REQ-026 reset_n=0 SHALL immediately force clk_seq=0, hres_q=0, FSM=IDLE, every 1-bit output 0.
REQ-027 Reset asserted mid-access SHALL abandon it; no cpu_ack issued for that request.
REQ-028 First cycle after release SHALL present clk_seq=0 with crtc_clk=1.

Configuration
REQ-029 Macro CGA_SNOW_EN: when defined and hres_q=1, GRANT SHALL occur the cycle after WAIT entry regardless of phase; if it coincides with a display read, vram_rd is still asserted, cpu_grant=1 too, and the strobes of REQ-017 fire unchanged (CPU data latched as display data = snow). When undefined, REQ-019/REQ-023 apply in all modes; low-res always uses windows.

Verification
REQ-030 Reset release, hres_mode=1, video_enabled=1 -> crtc_clk at clk_seq 0,16; vram_read_char at 3,19; vram_read_att at 5,21; charrom_read at 6,22; disp_pipeline at 7,23.
REQ-031 hres_mode=0 -> crtc_clk only at clk_seq 0; vram_read_char at 3 only; nothing in 16..31 except window at 24.
REQ-032 hres_mode toggled at clk_seq 10 -> timing unchanged until clk_seq 0 of next sequence, then new mode.
REQ-033 cpu_req raised at clk_seq 1, hres -> cpu_grant at clk_seq 8, cpu_ack at 10; held high -> next grant at 24, ack at 26.
REQ-034 CGA_SNOW_EN defined, hres, cpu_req raised at clk_seq 1 -> cpu_grant at 3 coincident with vram_read_char; undefined -> grant at 8.
REQ-035 reset_n low at GRANT cycle -> all outputs 0 within same cycle, no cpu_ack after release, clk_seq restarts at 0.
